// File: rtl/width_converter_stream_if.sv
// Stream bundle for the width converter: input beat side and output beat side.
// The converter binds the slave modport; the producer/consumer side binds master.
interface width_converter_stream_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
);
  localparam int KEEP_W = (OUT_WIDTH > IN_WIDTH) ? (OUT_WIDTH / IN_WIDTH) : 1;

  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic [KEEP_W-1:0]    out_keep;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_keep
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_keep
  );
endinterface

// File: rtl/width_converter_stream.sv
// Stream width converter: packs narrow beats into wide words (upsize), splits wide
// words into narrow beats (downsize), or acts as a one-deep register slice (equal).
// Full valid/ready backpressure on both sides, packet last, per-chunk keep on upsize.
module width_converter_stream #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  width_converter_stream_if.slave bus
);
  localparam int R     = (IN_WIDTH > OUT_WIDTH) ? (IN_WIDTH / OUT_WIDTH) : (OUT_WIDTH / IN_WIDTH);
  localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(R - 1);

  generate
    if (((IN_WIDTH > OUT_WIDTH) ? (IN_WIDTH % OUT_WIDTH) : (OUT_WIDTH % IN_WIDTH)) != 0) begin : g_bad_ratio
      $error("width_converter_stream: larger width must be an integer multiple of the smaller");
    end

    if (OUT_WIDTH > IN_WIDTH) begin : g_up
      typedef enum logic {FILL, HOLD} state_t;
      state_t               r_state;
      logic [IDX_W-1:0]     r_idx;
      logic [OUT_WIDTH-1:0] r_data;
      logic [R-1:0]         r_keep;
      logic                 r_last;
      logic                 r_valid;
      logic                 w_in_fire;
      logic                 w_out_fire;
      logic                 w_close;
      logic [IDX_W-1:0]     w_slot;
      logic [OUT_WIDTH-1:0] w_data_nxt;
      logic [R-1:0]         w_keep_nxt;

      // A beat accepted in HOLD can only arrive alongside the output transfer, so it opens a fresh word.
      assign w_slot     = (r_state == HOLD) ? '0 : r_idx;
      assign w_close    = (w_slot == LAST_SLOT) || bus.in_last;
      assign bus.in_ready = !rst && ((r_state == FILL) || bus.out_ready);
      assign w_in_fire  = bus.in_valid && bus.in_ready;
      assign w_out_fire = r_valid && bus.out_ready;

      // Merge the incoming beat into its slot; slot 0 starts a word from all-zero data/keep.
      always_comb begin
        w_data_nxt = (w_slot == '0) ? '0 : r_data;
        w_keep_nxt = (w_slot == '0) ? '0 : r_keep;
        for (int k = 0; k < R; k++) begin
          if (w_slot == IDX_W'(k)) begin
            w_data_nxt[(LSB_FIRST ? k : (R - 1 - k)) * IN_WIDTH +: IN_WIDTH] = bus.in_data;
            w_keep_nxt[k] = 1'b1;
          end
        end
      end

      // FILL/HOLD sequencing with registered valid/data/keep/last.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= FILL;
          r_idx   <= '0;
          r_data  <= '0;
          r_keep  <= '0;
          r_last  <= 1'b0;
          r_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_data <= w_data_nxt;
          r_keep <= w_keep_nxt;
          if (w_close) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_last  <= bus.in_last;
            r_idx   <= '0;
          end else begin
            r_state <= FILL;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= w_slot + IDX_W'(1);
          end
        end else if (w_out_fire) begin
          r_state <= FILL;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_idx   <= '0;
        end
      end

      assign bus.out_valid = r_valid;
      assign bus.out_data  = r_data;
      assign bus.out_last  = r_last;
      assign bus.out_keep  = r_keep;

    end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
      typedef enum logic {IDLE, EMIT} state_t;
      state_t               r_state;
      logic [IDX_W-1:0]     r_idx;
      logic [IN_WIDTH-1:0]  r_word;
      logic                 r_last;
      logic                 r_valid;
      logic                 w_at_end;
      logic                 w_in_fire;
      logic                 w_out_fire;
      logic [OUT_WIDTH-1:0] w_chunk;

      // A new word is only taken when the final chunk leaves this cycle, giving back-to-back words.
      assign w_at_end   = (r_idx == LAST_SLOT);
      assign bus.in_ready = !rst && ((r_state == IDLE) || (bus.out_ready && w_at_end));
      assign w_in_fire  = bus.in_valid && bus.in_ready;
      assign w_out_fire = r_valid && bus.out_ready;

      // Select the chunk addressed by the slot counter.
      always_comb begin
        w_chunk = '0;
        for (int k = 0; k < R; k++) begin
          if (r_idx == IDX_W'(k)) begin
            w_chunk = r_word[(LSB_FIRST ? k : (R - 1 - k)) * OUT_WIDTH +: OUT_WIDTH];
          end
        end
      end

      // IDLE/EMIT sequencing; idx advances only on an output transfer.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_word  <= '0;
          r_last  <= 1'b0;
          r_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_state <= EMIT;
          r_word  <= bus.in_data;
          r_last  <= bus.in_last;
          r_idx   <= '0;
          r_valid <= 1'b1;
        end else if (w_out_fire) begin
          if (w_at_end) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
      end

      assign bus.out_valid = r_valid;
      assign bus.out_data  = w_chunk;
      assign bus.out_last  = r_valid && r_last && w_at_end;
      assign bus.out_keep  = '1;

    end else begin : g_equal
      logic                 r_valid;
      logic [OUT_WIDTH-1:0] r_data;
      logic                 r_last;

      assign bus.in_ready = !rst && (!r_valid || bus.out_ready);

      // One-deep slice: load when empty or draining, otherwise hold.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_last  <= 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
          r_valid <= 1'b1;
          r_data  <= bus.in_data;
          r_last  <= bus.in_last;
        end else if (bus.out_ready) begin
          r_valid <= 1'b0;
        end
      end

      assign bus.out_valid = r_valid;
      assign bus.out_data  = r_data;
      assign bus.out_last  = r_last;
      assign bus.out_keep  = '1;
    end
  endgenerate
endmodule

// File: tb/tb_width_converter_stream.sv
// Bench for width_converter_stream: upsize 8->32 (LSB first), downsize 32->8 (MSB first)
// and equal 8->8 instances, directed cases plus randomized traffic against a packing model.
module tb_width_converter_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  width_converter_stream_if #(.IN_WIDTH(8),  .OUT_WIDTH(32)) up_if ();
  width_converter_stream_if #(.IN_WIDTH(32), .OUT_WIDTH(8))  dn_if ();
  width_converter_stream_if #(.IN_WIDTH(8),  .OUT_WIDTH(8))  eq_if ();

  width_converter_stream #(.IN_WIDTH(8),  .OUT_WIDTH(32), .LSB_FIRST(1'b1)) u_up (.clk(clk), .rst(rst), .bus(up_if.slave));
  width_converter_stream #(.IN_WIDTH(32), .OUT_WIDTH(8),  .LSB_FIRST(1'b0)) u_dn (.clk(clk), .rst(rst), .bus(dn_if.slave));
  width_converter_stream #(.IN_WIDTH(8),  .OUT_WIDTH(8),  .LSB_FIRST(1'b1)) u_eq (.clk(clk), .rst(rst), .bus(eq_if.slave));

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [3:0]  k;
  } beat_t;

  beat_t      q_up[$];
  beat_t      q_dn[$];
  beat_t      q_eq[$];
  logic [7:0] up_buf[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: bytes collect until four arrive or last; word = sum of byte_k << 8k.
  task automatic model_up(input logic [7:0] d, input logic l);
    beat_t b;
    up_buf.push_back(d);
    if (up_buf.size() == 4 || l) begin
      b.d = 32'h0;
      for (int k = 0; k < up_buf.size(); k++) b.d = b.d | (32'(up_buf[k]) << (8 * k));
      b.k = 4'((1 << up_buf.size()) - 1);
      b.l = l;
      q_up.push_back(b);
      up_buf.delete();
    end
  endtask

  // Reference: word split most-significant byte first; last only on the fourth byte.
  task automatic model_dn(input logic [31:0] w, input logic l);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.d = (w >> (8 * (3 - k))) & 32'hFF;
      b.l = l && (k == 3);
      b.k = 4'h1;
      q_dn.push_back(b);
    end
  endtask

  beat_t       e;
  logic        st_up = 1'b0, st_dn = 1'b0, st_eq = 1'b0;
  logic [36:0] pv_up;
  logic [8:0]  pv_dn, pv_eq;

  // Scoreboard and hold-while-stalled monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q_up.delete(); q_dn.delete(); q_eq.delete(); up_buf.delete();
      st_up = 1'b0; st_dn = 1'b0; st_eq = 1'b0;
    end else begin
      if (st_up) chk("up_stable", {up_if.out_valid, up_if.out_last, up_if.out_keep, up_if.out_data}, {1'b1, pv_up});
      if (st_dn) chk("dn_stable", {dn_if.out_valid, dn_if.out_last, dn_if.out_data}, {1'b1, pv_dn});
      if (st_eq) chk("eq_stable", {eq_if.out_valid, eq_if.out_last, eq_if.out_data}, {1'b1, pv_eq});
      st_up = up_if.out_valid && !up_if.out_ready; pv_up = {up_if.out_last, up_if.out_keep, up_if.out_data};
      st_dn = dn_if.out_valid && !dn_if.out_ready; pv_dn = {dn_if.out_last, dn_if.out_data};
      st_eq = eq_if.out_valid && !eq_if.out_ready; pv_eq = {eq_if.out_last, eq_if.out_data};

      if (up_if.out_valid && up_if.out_ready) begin
        if (q_up.size() == 0) chk("up_extra_beat", 1, 0);
        else begin e = q_up.pop_front(); chk("up_beat", {up_if.out_last, up_if.out_keep, up_if.out_data}, {e.l, e.k, e.d}); end
      end
      if (dn_if.out_valid && dn_if.out_ready) begin
        if (q_dn.size() == 0) chk("dn_extra_beat", 1, 0);
        else begin e = q_dn.pop_front(); chk("dn_beat", {dn_if.out_last, dn_if.out_keep, dn_if.out_data}, {e.l, 1'b1, e.d[7:0]}); end
      end
      if (eq_if.out_valid && eq_if.out_ready) begin
        if (q_eq.size() == 0) chk("eq_extra_beat", 1, 0);
        else begin e = q_eq.pop_front(); chk("eq_beat", {eq_if.out_last, eq_if.out_keep, eq_if.out_data}, {e.l, 1'b1, e.d[7:0]}); end
      end

      if (up_if.in_valid && up_if.in_ready) model_up(up_if.in_data, up_if.in_last);
      if (dn_if.in_valid && dn_if.in_ready) model_dn(dn_if.in_data, dn_if.in_last);
      if (eq_if.in_valid && eq_if.in_ready) begin
        e.d = {24'h0, eq_if.in_data}; e.l = eq_if.in_last; e.k = 4'h1;
        q_eq.push_back(e);
      end
    end
  end

  // Present one beat on stream `which` (0 up, 1 down, 2 equal) until accepted; call at posedge+1.
  task automatic send(input int which, input logic [31:0] d, input logic l);
    logic rdy;
    case (which)
      0: begin up_if.in_valid = 1'b1; up_if.in_data = d[7:0]; up_if.in_last = l; end
      1: begin dn_if.in_valid = 1'b1; dn_if.in_data = d;      dn_if.in_last = l; end
      default: begin eq_if.in_valid = 1'b1; eq_if.in_data = d[7:0]; eq_if.in_last = l; end
    endcase
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      rdy = (which == 0) ? up_if.in_ready : (which == 1) ? dn_if.in_ready : eq_if.in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        up_if.in_valid = 1'b0; dn_if.in_valid = 1'b0; eq_if.in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    up_if.in_valid = 1'b0; dn_if.in_valid = 1'b0; eq_if.in_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_up"}, {up_if.in_ready, up_if.out_valid, up_if.out_last, up_if.out_keep, up_if.out_data}, 64'h0);
    chk({tag, "_dn"}, {dn_if.in_ready, dn_if.out_valid, dn_if.out_last, dn_if.out_data}, 64'h0);
    chk({tag, "_eq"}, {eq_if.in_ready, eq_if.out_valid, eq_if.out_last, eq_if.out_data}, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [7:0] t3_exp [4];
  int         bad_rdy, bad_ov;
  logic       acc_u, acc_d, acc_e;

  initial begin
    up_if.in_valid = 1'b0; up_if.in_data = '0; up_if.in_last = 1'b0; up_if.out_ready = 1'b1;
    dn_if.in_valid = 1'b0; dn_if.in_data = '0; dn_if.in_last = 1'b0; dn_if.out_ready = 1'b1;
    eq_if.in_valid = 1'b0; eq_if.in_data = '0; eq_if.in_last = 1'b0; eq_if.out_ready = 1'b1;
    t3_exp[0] = 8'hDE; t3_exp[1] = 8'hAD; t3_exp[2] = 8'hBE; t3_exp[3] = 8'hEF;

    @(negedge clk); check_reset("reset");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {up_if.in_ready, dn_if.in_ready, eq_if.in_ready, up_if.out_valid, dn_if.out_valid, eq_if.out_valid}, 6'b111000);
    @(posedge clk); #1;

    // T1: full word, last on the fourth beat.
    send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0); send(0, 8'h44, 1);
    @(negedge clk);
    chk("t1_word", {up_if.out_valid, up_if.out_last, up_if.out_keep, up_if.out_data}, {1'b1, 1'b1, 4'hF, 32'h44332211});
    @(posedge clk); #1;

    // T2: short packet then a fresh word from slot 0.
    send(0, 8'hAA, 0); send(0, 8'hBB, 1);
    @(negedge clk);
    chk("t2_short", {up_if.out_valid, up_if.out_last, up_if.out_keep, up_if.out_data}, {1'b1, 1'b1, 4'h3, 32'h0000BBAA});
    @(posedge clk); #1;
    send(0, 8'h55, 0); send(0, 8'h66, 0); send(0, 8'h77, 0); send(0, 8'h88, 0);
    @(negedge clk);
    chk("t2_next", {up_if.out_valid, up_if.out_last, up_if.out_keep, up_if.out_data}, {1'b1, 1'b0, 4'hF, 32'h88776655});
    @(posedge clk); #1;

    send(2, 8'h5A, 1);
    @(negedge clk);
    chk("eq_slice", {eq_if.out_valid, eq_if.out_last, eq_if.out_keep, eq_if.out_data}, {1'b1, 1'b1, 1'b1, 8'h5A});
    @(posedge clk); #1;

    // T3: MSB-first split with last only on the final byte.
    send(1, 32'hDEADBEEF, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_chunk", {dn_if.out_valid, dn_if.out_last, dn_if.out_data}, {1'b1, (k == 3), t3_exp[k]});
    end
    @(negedge clk); chk("t3_idle", dn_if.out_valid, 0);
    @(posedge clk); #1;

    // T4a: downsize stall holds chunk 0 and refuses the next word.
    dn_if.out_ready = 1'b0;
    send(1, 32'h12345678, 0);
    dn_if.in_valid = 1'b1; dn_if.in_data = 32'hCAFEF00D; dn_if.in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_dn_hold", {dn_if.out_valid, dn_if.in_ready, dn_if.out_data}, {1'b1, 1'b0, 8'h12});
      @(posedge clk); #1;
    end
    dn_if.out_ready = 1'b1;
    send(1, 32'hCAFEF00D, 1);
    repeat (6) @(posedge clk); #1;

    // T4b: upsize HOLD under stall, then output transfer and new beat in the same cycle.
    up_if.out_ready = 1'b0;
    send(0, 8'h9A, 0); send(0, 8'hBC, 0); send(0, 8'hDE, 0); send(0, 8'hF0, 0);
    up_if.in_valid = 1'b1; up_if.in_data = 8'h77; up_if.in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_up_hold", {up_if.out_valid, up_if.in_ready, up_if.out_data}, {1'b1, 1'b0, 32'hF0DEBC9A});
      @(posedge clk); #1;
    end
    up_if.out_ready = 1'b1;
    send(0, 8'h77, 1);
    @(negedge clk);
    chk("t4_up_overlap", {up_if.out_valid, up_if.out_last, up_if.out_keep, up_if.out_data}, {1'b1, 1'b1, 4'h1, 32'h00000077});
    @(posedge clk); #1;

    // T5: continuous traffic -> in_ready stays high, out_valid on every fourth cycle.
    bad_rdy = 0; bad_ov = 0;
    for (int i = 0; i < 32; i++) begin
      up_if.in_valid = 1'b1; up_if.in_data = 8'($urandom); up_if.in_last = 1'b0;
      @(negedge clk);
      if (!up_if.in_ready) bad_rdy++;
      if (up_if.out_valid != (i > 0 && (i % 4) == 0)) bad_ov++;
      @(posedge clk); #1;
    end
    up_if.in_valid = 1'b0;
    chk("t5_in_ready_drops", bad_rdy, 0);
    chk("t5_out_valid_cadence", bad_ov, 0);
    repeat (2) @(posedge clk); #1;

    // T6: reset mid-word discards the partial word.
    send(0, 8'hA1, 0); send(0, 8'hA2, 0);
    rst = 1'b1;
    @(negedge clk); check_reset("t6_reset");
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("t6_after", {up_if.out_valid, up_if.in_ready}, 2'b01);
    @(posedge clk); #1;
    send(0, 8'hB1, 0); send(0, 8'hB2, 0); send(0, 8'hB3, 0); send(0, 8'hB4, 0);
    @(negedge clk);
    chk("t6_clean_word", {up_if.out_valid, up_if.out_last, up_if.out_keep, up_if.out_data}, {1'b1, 1'b0, 4'hF, 32'hB4B3B2B1});
    @(posedge clk); #1;

    // Randomized traffic on all three instances; a presented beat is held until accepted.
    acc_u = 1'b0; acc_d = 1'b0; acc_e = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      if (!up_if.in_valid || acc_u) begin
        up_if.in_valid = ($urandom % 4) != 0; up_if.in_data = 8'($urandom); up_if.in_last = ($urandom % 5) == 0;
      end
      if (!dn_if.in_valid || acc_d) begin
        dn_if.in_valid = ($urandom % 3) != 0; dn_if.in_data = $urandom; dn_if.in_last = ($urandom % 3) == 0;
      end
      if (!eq_if.in_valid || acc_e) begin
        eq_if.in_valid = ($urandom % 4) != 0; eq_if.in_data = 8'($urandom); eq_if.in_last = ($urandom % 4) == 0;
      end
      up_if.out_ready = ($urandom % 4) != 0;
      dn_if.out_ready = ($urandom % 4) != 0;
      eq_if.out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      acc_u = up_if.in_valid && up_if.in_ready;
      acc_d = dn_if.in_valid && dn_if.in_ready;
      acc_e = eq_if.in_valid && eq_if.in_ready;
      @(posedge clk); #1;
    end
    up_if.in_valid = 1'b0; dn_if.in_valid = 1'b0; eq_if.in_valid = 1'b0;
    up_if.out_ready = 1'b1; dn_if.out_ready = 1'b1; eq_if.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("drain_up", q_up.size(), 0);
    chk("drain_dn", q_dn.size(), 0);
    chk("drain_eq", q_eq.size(), 0);
    chk("drain_idle", {up_if.out_valid, dn_if.out_valid, eq_if.out_valid}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
